// File: rtl/jt12_pg_accum.sv
// Phase accumulator: detune + MUL + 20-bit per-slot phase, 24 slots through a shift-register memory.
// Optional JT12_PG_FULLPHASE_EN adds a phase_full output carrying the whole registered phase.
module jt12_pg_accum #(
  parameter int SLOTS = 24,
  parameter int PW    = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        zero,
  input  logic [18:0] phinc_pure,
  input  logic [5:0]  detoff,
  input  logic [3:0]  mul,
  input  logic        keyon,
  output logic [9:0]  phase_op,
  output logic [4:0]  slot_out
`ifdef JT12_PG_FULLPHASE_EN
  ,
  output logic [PW-1:0] phase_full
`endif
);

  localparam int DW = 17;
  localparam logic [4:0] LAST = 5'(SLOTS - 1);

  typedef struct packed {
    logic [DW-1:0] det;
    logic [3:0]    mul;
    logic          keyon;
    logic [4:0]    slot;
  } s1_t;

  typedef struct packed {
    logic [PW-1:0] inc;
    logic          keyon;
    logic [4:0]    slot;
  } s2_t;

  logic [4:0]              cnt;
  logic [4:0]              slot0;
  logic [4:0]              cnt_nxt;
  logic [19:0]             det_full;
  logic [PW:0]             prod;
  logic [PW-1:0]           inc;
  logic [PW-1:0]           ph_new;
  logic [SLOTS-1:0][PW-1:0] mem;
  s1_t                     s1;
  s2_t                     s2;
  logic                    unused_bits;

  // zero realigns the counter to the incoming stream, whatever its value
  assign slot0   = zero ? 5'd0 : cnt;
  assign cnt_nxt = (slot0 == LAST) ? 5'd0 : slot0 + 5'd1;

  // detune result wraps modulo 2^17; no saturation
  assign det_full = {1'b0, phinc_pure} + {{14{detoff[5]}}, detoff};

  assign prod = {{(PW + 1 - DW){1'b0}}, s1.det} * {{(PW + 1 - 4){1'b0}}, s1.mul};
  assign inc  = (s1.mul == 4'd0) ? {{(PW - DW + 1){1'b0}}, s1.det[DW-1:1]} : prod[PW-1:0];

  // oldest memory entry is the same slot written SLOTS enabled cycles ago
  assign ph_new = s2.keyon ? '0 : mem[SLOTS-1] + s2.inc;

  assign unused_bits = ^{det_full[19:DW], prod[PW], phinc_pure[18:DW]};

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      s1       <= '0;
      s2       <= '0;
      mem      <= '0;
      phase_op <= '0;
      slot_out <= '0;
`ifdef JT12_PG_FULLPHASE_EN
      phase_full <= '0;
`endif
    end else if (clk_en) begin
      cnt <= cnt_nxt;

      s1.det   <= det_full[DW-1:0];
      s1.mul   <= mul;
      s1.keyon <= keyon;
      s1.slot  <= slot0;

      s2.inc   <= inc;
      s2.keyon <= s1.keyon;
      s2.slot  <= s1.slot;

      mem      <= {mem[SLOTS-2:0], ph_new};
      phase_op <= ph_new[PW-1:PW-10];
      slot_out <= s2.slot;
`ifdef JT12_PG_FULLPHASE_EN
      phase_full <= ph_new;
`endif
    end
  end

endmodule

// File: tb/tb_jt12_pg_accum.sv
// Directed bench for jt12_pg_accum: slot frames with hand-computed phases, clk_en freeze, reset, realign.
module tb_jt12_pg_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        zero;
  logic [18:0] phinc_pure;
  logic [5:0]  detoff;
  logic [3:0]  mul;
  logic        keyon;
  logic [9:0]  phase_op;
  logic [4:0]  slot_out;
`ifdef JT12_PG_FULLPHASE_EN
  logic [19:0] phase_full;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  logic [18:0] c_ph  [24];
  logic [5:0]  c_det [24];
  logic [3:0]  c_mul [24];
  logic        c_key [24];
  logic [9:0]  cap_op   [32];
  logic [19:0] cap_full [32];

  jt12_pg_accum dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .zero       (zero),
    .phinc_pure (phinc_pure),
    .detoff     (detoff),
    .mul        (mul),
    .keyon      (keyon),
    .phase_op   (phase_op),
    .slot_out   (slot_out)
`ifdef JT12_PG_FULLPHASE_EN
    ,
    .phase_full (phase_full)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected end of test");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic z, input logic [18:0] ph, input logic [5:0] dt,
                      input logic [3:0] m, input logic k);
    zero = z; phinc_pure = ph; detoff = dt; mul = m; keyon = k;
    @(posedge clk); #1;
    if (clk_en) begin
      cap_op[slot_out] = phase_op;
`ifdef JT12_PG_FULLPHASE_EN
      cap_full[slot_out] = phase_full;
`endif
    end
  endtask

  // one pass over all slots; optional clk_en pause or reset at a given slot
  task automatic frame(input int pause_at, input logic [9:0] pause_op, input int rst_at);
    for (int s = 0; s < 24; s++) begin
      if (s == rst_at) begin
        rst = 1'b1; zero = 1'b1; keyon = 1'b1; phinc_pure = 19'h7FFFF; mul = 4'd15;
        @(posedge clk); #1;
        check("rst_mid_op", 32'(phase_op), 32'h0);
        check("rst_mid_slot", 32'(slot_out), 32'h0);
`ifdef JT12_PG_FULLPHASE_EN
        check("rst_mid_full", 32'(phase_full), 32'h0);
`endif
        rst = 1'b0;
        return;
      end
      if (s == pause_at) begin
        clk_en = 1'b0;
        for (int c = 0; c < 10; c++) begin
          zero = c[0]; keyon = 1'b1; phinc_pure = 19'h12345; mul = 4'd7;
          @(posedge clk); #1;
          check("hold_slot", 32'(slot_out), 32'd5);
          check("hold_op", 32'(phase_op), 32'(pause_op));
        end
        clk_en = 1'b1;
      end
      step(s == 0, c_ph[s], c_det[s], c_mul[s], c_key[s]);
    end
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b1; zero = 1'b0;
    phinc_pure = '0; detoff = '0; mul = '0; keyon = 1'b0;
    for (int i = 0; i < 24; i++) begin
      c_ph[i] = '0; c_det[i] = '0; c_mul[i] = 4'd1; c_key[i] = 1'b0;
    end
    for (int i = 0; i < 32; i++) begin
      cap_op[i] = '0; cap_full[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_op", 32'(phase_op), 32'h0);
    check("reset_slot", 32'(slot_out), 32'h0);
`ifdef JT12_PG_FULLPHASE_EN
    check("reset_full", 32'(phase_full), 32'h0);
`endif
    rst = 1'b0;

    c_ph[0]  = 19'h00100; c_key[0] = 1'b1;
    c_ph[2]  = 19'h00300; c_key[2] = 1'b1;
    c_ph[3]  = 19'h1FFE0; c_mul[3] = 4'd8; c_key[3] = 1'b1;
    c_ph[5]  = 19'h00400; c_mul[5] = 4'd0;
    c_ph[9]  = 19'h00002; c_det[9] = 6'b111100; c_key[9] = 1'b1;
    c_ph[12] = 19'h00800;

    frame(-1, '0, -1);
    check("f1_op0_keyed", 32'(cap_op[0]), 32'h0);
    check("f1_op5", 32'(cap_op[5]), 32'h0);
    check("f1_op12", 32'(cap_op[12]), 32'h2);
    check("f1_op2_keyed", 32'(cap_op[2]), 32'h0);
`ifdef JT12_PG_FULLPHASE_EN
    check("f1_full0", 32'(cap_full[0]), 32'h0);
    check("f1_full5_mul0", 32'(cap_full[5]), 32'h200);
`endif

    c_key[0] = 1'b0; c_key[3] = 1'b0; c_key[9] = 1'b0;
    frame(-1, '0, -1);
    check("f2_op3", 32'(cap_op[3]), 32'h3FF);
    check("f2_op9_neg_det", 32'(cap_op[9]), 32'h07F);
    check("f2_op5", 32'(cap_op[5]), 32'h1);
    check("f2_op12", 32'(cap_op[12]), 32'h4);
    check("f2_op2_keyed", 32'(cap_op[2]), 32'h0);
`ifdef JT12_PG_FULLPHASE_EN
    check("f2_full0", 32'(cap_full[0]), 32'h100);
    check("f2_full3", 32'(cap_full[3]), 32'hFFF00);
    check("f2_full9", 32'(cap_full[9]), 32'h1FFFE);
`endif

    c_ph[3] = 19'h00400; c_mul[3] = 4'd0;
    c_ph[9] = 19'h0;     c_det[9] = 6'd0;
    c_mul[5] = 4'd15;
    frame(-1, '0, -1);
    check("f3_op3_wrap", 32'(cap_op[3]), 32'h0);
    check("f3_op9_hold", 32'(cap_op[9]), 32'h07F);
    check("f3_op5_mul15", 32'(cap_op[5]), 32'h10);
    check("f3_op12", 32'(cap_op[12]), 32'h6);
`ifdef JT12_PG_FULLPHASE_EN
    check("f3_full3_wrap", 32'(cap_full[3]), 32'h00100);
    check("f3_full5", 32'(cap_full[5]), 32'h04000);
`endif

    frame(-1, '0, -1);
    check("f4_op0", 32'(cap_op[0]), 32'h0);
    check("f4_op5", 32'(cap_op[5]), 32'h1F);
    check("f4_op12", 32'(cap_op[12]), 32'h8);

    frame(-1, '0, -1);
    check("f5_op0", 32'(cap_op[0]), 32'h1);
    check("f5_op5", 32'(cap_op[5]), 32'h2E);
`ifdef JT12_PG_FULLPHASE_EN
    check("f5_full0", 32'(cap_full[0]), 32'h400);
`endif

    frame(8, 10'h3D, -1);
    check("f6_op5", 32'(cap_op[5]), 32'h3D);
    check("f6_op12_after_hold", 32'(cap_op[12]), 32'hC);
    check("f6_op0", 32'(cap_op[0]), 32'h1);
`ifdef JT12_PG_FULLPHASE_EN
    check("f6_full12", 32'(cap_full[12]), 32'h3000);
`endif

    frame(-1, '0, 10);
    frame(-1, '0, -1);
    check("post_rst_op12", 32'(cap_op[12]), 32'h2);
    check("post_rst_op5", 32'(cap_op[5]), 32'hF);
    check("post_rst_op3", 32'(cap_op[3]), 32'h0);
    check("post_rst_op2_keyed", 32'(cap_op[2]), 32'h0);
`ifdef JT12_PG_FULLPHASE_EN
    check("post_rst_full0", 32'(cap_full[0]), 32'h100);
    check("post_rst_full3", 32'(cap_full[3]), 32'h200);
`endif

    // counter is 0 here; zero arrives while it reads 7
    for (int i = 0; i < 7; i++) step(1'b0, '0, '0, 4'd1, 1'b0);
    step(1'b1, '0, '0, 4'd1, 1'b0);
    step(1'b0, '0, '0, 4'd1, 1'b0);
    check("realign_pre", 32'(slot_out), 32'd6);
    step(1'b0, '0, '0, 4'd1, 1'b0);
    check("realign_slot0", 32'(slot_out), 32'd0);
    step(1'b0, '0, '0, 4'd1, 1'b0);
    check("realign_slot1", 32'(slot_out), 32'd1);

    frame(-1, '0, -1);
    check("final_op2_keyed", 32'(cap_op[2]), 32'h0);
    check("final_slot_out", 32'(slot_out), 32'd21);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/jt12_pg_accum.md
Name: jt12_pg_accum

Overview:
- Phase accumulator stage directly downstream of the phase-increment calculator (block/fnum/PM → phinc_pure).
- Applies a pre-computed detune offset and the MUL factor, then accumulates a 20-bit phase per operator slot.
- 24 slots are time-multiplexed through a shift-register memory.
- Feeds the top 10 phase bits to the operator/sine stage.

Parameters:
- SLOTS, 24, number of time-multiplexed operator slots (slot memory depth)
- PW, 20, phase accumulator width in bits

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- clk_en  in  1  clock enable; all state advances only when high
- zero  in  1  marks that the input currently presented belongs to slot 0
- phinc_pure  in  19  pure phase increment from upstream, for the current slot
- detoff  in  6  signed detune offset for the current slot
- mul  in  4  frequency multiplier for the current slot
- keyon  in  1  phase reset request for the current slot
- phase_op  out  10  phase[19:10] of the slot leaving stage 3
- slot_out  out  5  slot index associated with phase_op

Behaviour:
- One clock, clk; reset rst is synchronous and active-high. Everything below happens on rising clk with clk_en=1; with clk_en=0 all registers hold.
- Reset clears:
  - all pipeline registers
  - all SLOTS memory entries, to 0
  - phase_op=0, slot_out=0
  - internal slot counter=0
- Reset asserted mid-operation wins over clk_en and zero in that cycle.
- Slot counter:
  - Stage-0 counter counts 0..SLOTS-1, then wraps to 0.
  - When zero=1, the current input is treated as slot 0 and the counter loads 1 for the next cycle. This resynchronises to the input.
  - zero asserted at a counter value other than 0 forces the realignment; no error is flagged.
- Stage 1, detune:
  - det = {1'b0,phinc_pure} + sign-extended detoff, 20-bit arithmetic.
  - Keep det[16:0]; wrap modulo 2^17. Negative results wrap; they do not saturate.
  - Register det, mul, keyon and slot.
- Stage 2, multiply:
  - mul==0: inc = det>>1.
  - Otherwise: inc = det*mul, truncated to 20 bits.
  - Register inc, keyon and slot.
- Stage 3, accumulate:
  - ph_in = oldest slot-memory entry.
  - ph_new = keyon_d2 ? 0 : (ph_in + inc) mod 2^20.
  - ph_new is pushed into the slot memory, which shifts by one.
  - phase_op = ph_new[19:10] and slot_out = slot_d2, both registered.
- Slot alignment: the slot memory is arranged so the entry read in stage 3 is the same slot's value written SLOTS clk_en cycles earlier.
- Latency: 3 clk_en cycles from an input to its phase_op/slot_out.
- A slot's phase advances once per SLOTS clk_en cycles.
- keyon timing: keyon is delayed to stage 3 alongside its data. With keyon held high, the slot's phase stays at 0 and phase_op=0 for that slot.
- Accumulator overflow wraps silently.
- keyon=1 and zero=1 in the same cycle are independent; both take effect.

Optional Feature:
- Macro JT12_PG_FULLPHASE_EN.
- Defined:
  - Adds output port phase_full [PW-1:0], equal to the registered full ph_new, same timing as phase_op, reset to 0.
  - Used by the envelope/debug taps.
- Undefined: port absent; behaviour otherwise identical.

Test Plan:
1. Reset, then pulse zero; slot 0 only: phinc_pure=0x100, detoff=0, mul=1, keyon=1 on the first pass, then 0. Other slots: phinc=0.
   -> Slot-0 phase_full is 0x100*N after the Nth unkeyed visit; phase_op increments by 1 every 4 slot-0 visits.
2. Slot 5: phinc_pure=0x400, mul=0 -> per-visit increment 0x200. Same slot with mul=15 -> increment 0x3C00.
3. phinc_pure=2, detoff=-4 (6'b111100), mul=1 -> increment 0x1FFFE. Phase after one visit from 0 is 0x1FFFE; phase_op=0x07F.
4. Slot 3 at phase 0xFFF00 with increment 0x200 -> wraps to 0x00100, phase_op=0.
5. clk_en low for 10 cycles mid-stream -> outputs and memory frozen; resumes with the exact sequence continuing. Assert rst mid-stream -> next cycle all outputs 0 and every slot's phase restarts from 0.
6. zero pulsed at counter value 7 -> slot_out reads 0 three clk_en cycles later. keyon held on slot 2 -> phase_op for slot 2 constantly 0.
